time_counter: RTL and testbench

Real-time hour/minute/second counter feeding the set-time control stage. It divides the 50 MHz system clock down to a 1 Hz tick and advances a 24-hour HH:MM:SS count. It drives the `show_hou`/`show_min`/`show_sec` values that the control stage displays and edits. While the control stage asserts `stop_clk`, the counter freezes and tracks the edited time from the control stage's `hou`/`min`/`sec` outputs, then resumes counting from that value.

---
 rtl/time_counter.sv | 110 +++++++++++
 tb/tb_time_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// time_counter: divides the system clock to a 1 Hz step and keeps a 24-hour
// HH:MM:SS count. While stop_clk is high the count freezes and follows the
// (range-clamped) set values from the control stage, then resumes from them.
module time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk_50Mhz,
  input  logic       rst_n,
  input  logic       stop_clk,
  input  logic [6:0] set_hou,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  output logic [6:0] show_hou,
  output logic [6:0] show_min,
  output logic [6:0] show_sec,
  output logic       sec_tick,
  output logic       day_wrap
);

  // A one-cycle-per-second clock still needs a one-bit prescaler register.
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       hou_q, hou_d;
  logic [6:0]       min_q, min_d;
  logic [6:0]       sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [6:0] loadHou;
  logic [6:0] loadMin;
  logic [6:0] loadSec;
  logic       secCarry;
  logic       minCarry;
  logic       houCarry;

  // Out-of-range edit values load as zero so the count never leaves its range.
  always_comb begin
    loadHou = (set_hou >= 7'd24) ? 7'd0 : set_hou;
    loadMin = (set_min >= 7'd60) ? 7'd0 : set_min;
    loadSec = (set_sec >= 7'd60) ? 7'd0 : set_sec;
  end

  // Ripple-carry terms of the second step, all resolved in the same cycle.
  always_comb begin
    secCarry = (sec_q == 7'd59);
    minCarry = secCarry && (min_q == 7'd59);
    houCarry = minCarry && (hou_q == 7'd23);
  end

  // Next state: HOLD loads and parks the prescaler; RUN counts and steps time.
  always_comb begin
    pre_d  = pre_q;
    hou_d  = hou_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (stop_clk) begin
      pre_d = '0;
      hou_d = loadHou;
      min_d = loadMin;
      sec_d = loadSec;
    end else if (pre_q == PRE_TERM) begin
      pre_d  = '0;
      tick_d = 1'b1;
      sec_d  = secCarry ? 7'd0 : sec_q + 7'd1;
      if (secCarry) begin
        min_d = (min_q == 7'd59) ? 7'd0 : min_q + 7'd1;
      end
      if (minCarry) begin
        hou_d = (hou_q == 7'd23) ? 7'd0 : hou_q + 7'd1;
      end
      wrap_d = houCarry;
    end else begin
      pre_d = pre_q + PRE_ONE;
    end
  end

  // State register; reset clears the time, the prescaler and both pulses.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      hou_q  <= 7'd0;
      min_q  <= 7'd0;
      sec_q  <= 7'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      hou_q  <= hou_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    show_hou = hou_q;
    show_min = min_q;
    show_sec = sec_q;
    sec_tick = tick_q;
    day_wrap = wrap_q;
  end

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: drives time_counter with directed and random stimulus.
// A reference model keeps time as seconds-since-midnight plus a cycle phase;
// expected outputs are queued per cycle and a monitor compares them.
module tb_time_counter;

  localparam int CLK_HZ  = 4;
  localparam int DAY_SEC = 86400;

  typedef struct packed {
    logic [6:0] hou;
    logic [6:0] min;
    logic [6:0] sec;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic       clk_50Mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       stop_clk  = 1'b0;
  logic [6:0] set_hou   = 7'd0;
  logic [6:0] set_min   = 7'd0;
  logic [6:0] set_sec   = 7'd0;
  logic [6:0] show_hou;
  logic [6:0] show_min;
  logic [6:0] show_sec;
  logic       sec_tick;
  logic       day_wrap;

  exp_t expQ[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   tbTicks    = 0;
  int   tbWraps    = 0;
  int   mSecs      = 0;
  int   mPhase     = 0;

  time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk_50Mhz(clk_50Mhz),
    .rst_n    (rst_n),
    .stop_clk (stop_clk),
    .set_hou  (set_hou),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .show_hou (show_hou),
    .show_min (show_min),
    .show_sec (show_sec),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap)
  );

  // Free-running clock.
  always #5 clk_50Mhz = ~clk_50Mhz;

  function automatic int clampVal(input int v, input int lim);
    return (v >= lim) ? 0 : v;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the model's
  // prediction of the outputs after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic stop,
                               input int h, input int m, input int s);
    exp_t e;
    @(negedge clk_50Mhz);
    rst_n    = rst;
    stop_clk = stop;
    set_hou  = 7'(h);
    set_min  = 7'(m);
    set_sec  = 7'(s);
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (!rst) begin
      mSecs  = 0;
      mPhase = 0;
    end else if (stop) begin
      mSecs  = clampVal(h, 24) * 3600 + clampVal(m, 60) * 60 + clampVal(s, 60);
      mPhase = 0;
    end else begin
      mPhase++;
      if (mPhase == CLK_HZ) begin
        mPhase = 0;
        mSecs  = (mSecs + 1) % DAY_SEC;
        e.tick = 1'b1;
        e.wrap = (mSecs == 0);
      end
    end
    e.hou = 7'(mSecs / 3600);
    e.min = 7'((mSecs / 60) % 60);
    e.sec = 7'(mSecs % 60);
    expQ.push_back(e);
  endtask

  // Directed check of the outputs just after the next rising edge.
  task automatic checkOutput(input string name, input int h, input int m,
                             input int s, input logic t, input logic w);
    @(posedge clk_50Mhz);
    #1;
    vectors++;
    if ({show_hou, show_min, show_sec, sec_tick, day_wrap} !==
        {7'(h), 7'(m), 7'(s), t, w}) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d:%0d:%0d tick=%b wrap=%b, want %0d:%0d:%0d tick=%b wrap=%b",
               name, show_hou, show_min, show_sec, sec_tick, day_wrap, h, m, s, t, w);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Scoreboard monitor: one queued prediction per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50Mhz);
      #1;
      if (sec_tick === 1'b1) tbTicks++;
      if (day_wrap === 1'b1) tbWraps++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        vectors++;
        if ({show_hou, show_min, show_sec, sec_tick, day_wrap} !== e) begin
          miscompares++;
          $display("[TB] FAIL scoreboard @%0t: got %0d:%0d:%0d tick=%b wrap=%b, want %0d:%0d:%0d tick=%b wrap=%b",
                   $time, show_hou, show_min, show_sec, sec_tick, day_wrap,
                   e.hou, e.min, e.sec, e.tick, e.wrap);
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int h, m, s;
    logic rst, stop;

    // Reset asserted in the middle of a run.
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (6) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    #1;
    vectors++;
    if ({show_hou, show_min, show_sec, sec_tick, day_wrap} !== 23'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %0d:%0d:%0d tick=%b wrap=%b, want 0:0:0 tick=0 wrap=0",
               show_hou, show_min, show_sec, sec_tick, day_wrap);
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    checkOutput("reset_hold", 0, 0, 0, 1'b0, 1'b0);

    // First ticks after release.
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("first_tick", 0, 0, 1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("second_tick", 0, 0, 2, 1'b1, 1'b0);

    // Load 23:59:58 and resume through midnight.
    applyStimulus(1'b1, 1'b1, 23, 59, 58);
    checkOutput("load", 23, 59, 58, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 23, 59, 58);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("resume_step", 23, 59, 59, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("midnight", 0, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("wrap_one_cycle", 0, 0, 0, 1'b0, 1'b0);

    // Minute and hour carry.
    applyStimulus(1'b1, 1'b1, 9, 59, 59);
    checkOutput("load_carry", 9, 59, 59, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("hour_carry", 10, 0, 0, 1'b1, 1'b0);

    // Clamp of out-of-range and maximal in-range edits.
    applyStimulus(1'b1, 1'b1, 30, 75, 60);
    checkOutput("clamp_high", 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 24, 60, 59);
    checkOutput("clamp_edge", 0, 0, 59, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 23, 59, 59);
    checkOutput("clamp_max", 23, 59, 59, 1'b0, 1'b0);

    // Stop exactly on the terminal-count edge: the load wins.
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 12, 12, 12);
    checkOutput("stop_at_term", 12, 12, 12, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("after_stop", 12, 12, 13, 1'b1, 1'b0);

    // Long run from 23:40:00 for 1500 seconds, crossing midnight once.
    applyStimulus(1'b1, 1'b1, 23, 40, 0);
    checkOutput("long_load", 23, 40, 0, 1'b0, 1'b0);
    tbTicks = 0;
    tbWraps = 0;
    repeat (1500 * CLK_HZ - 1) applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkOutput("long_final", 0, 5, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkCount("long_ticks", tbTicks, 1500);
    checkCount("long_wraps", tbWraps, 1);

    // Random mix of runs, edits (often out of range) and resets.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(199, 0) != 0);
      stop = ($urandom_range(15, 0) == 0);
      if ($urandom_range(1, 0) == 1) begin
        h = $urandom_range(127, 0);
        m = $urandom_range(127, 0);
        s = $urandom_range(127, 0);
      end else begin
        h = $urandom_range(23, 22);
        m = $urandom_range(59, 58);
        s = $urandom_range(59, 50);
      end
      applyStimulus(rst, stop, h, m, s);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk_50Mhz);
      #2;
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d predictions left, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
